// File: rtl/decode_stage.sv
// RV32I/RV64I instruction-decode pipeline stage: combinational decode of instr_i
// into a control bundle, held in a registered output stage behind a 2-entry skid buffer.

package core_pkg;
   typedef enum logic [1:0] {Add = 2'd0, Funct = 2'd1, Op32 = 2'd2} aluop_e;
   typedef enum logic [1:0] {JmpNone = 2'd0, Jal = 2'd1, Jalr = 2'd2} jump_e;
   typedef enum logic [1:0] {MemNone = 2'd0, MemLoad = 2'd1, MemStore = 2'd2} mem_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpReg32  = 7'b0111011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam logic [31:0] EcallEnc  = 32'h0000_0073;
   localparam logic [31:0] EbreakEnc = 32'h0010_0073;
endpackage

module decode_stage
   import core_pkg::*;
#(
   parameter int Xlen = 64,
   parameter int Ilen = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [Ilen-1:0] instr_i,
   input  logic [Xlen-1:0] pc_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [Xlen-1:0] pc_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic [Xlen-1:0] imm_o,
   output logic [1:0]      aluop_o,
   output logic            alu_use_imm_o,
   output logic            reg_wb_o,
   output logic            reg_lui_o,
   output logic            is_auipc_o,
   output logic            branch_o,
   output logic            mem_to_reg_o,
   output logic [1:0]      jump_o,
   output logic [1:0]      mem_type_o,
   output logic            ecall_o,
   output logic            ebreak_o,
   output logic            fence_o,
   output logic            illegal_o
);

   localparam bit Rv32 = (Xlen == 32);

   typedef struct packed {
      logic [Xlen-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [Xlen-1:0] imm;
      aluop_e          aluop;
      logic            alu_use_imm;
      logic            reg_wb;
      logic            reg_lui;
      logic            is_auipc;
      logic            branch;
      logic            mem_to_reg;
      jump_e           jump;
      mem_e            mem_type;
      logic            ecall;
      logic            ebreak;
      logic            fence;
      logic            illegal;
   } bundle_t;

   typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [Xlen-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            legal;
   bundle_t         dec;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign imm_i  = Xlen'($signed(instr_i[31:20]));
   assign imm_s  = Xlen'($signed({instr_i[31:25], instr_i[11:7]}));
   assign imm_b  = Xlen'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
   assign imm_u  = Xlen'($signed({instr_i[31:12], 12'b0}));
   assign imm_j  = Xlen'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dec   = '0;
      legal = 1'b1;
      // All valid opcodes end in 2'b11, so non-32-bit encodings land in default.
      case (opcode)
         OpLoad: begin
            dec.alu_use_imm = 1'b1;
            dec.reg_wb      = 1'b1;
            dec.mem_to_reg  = 1'b1;
            dec.mem_type    = MemLoad;
            dec.imm         = imm_i;
            legal = (funct3 != 3'b111) && !(Rv32 && (funct3 == 3'b011 || funct3 == 3'b110));
         end
         OpStore: begin
            dec.alu_use_imm = 1'b1;
            dec.mem_type    = MemStore;
            dec.imm         = imm_s;
            legal = !funct3[2] && !(Rv32 && funct3 == 3'b011);
         end
         OpBranch: begin
            dec.branch = 1'b1;
            dec.imm    = imm_b;
            legal      = (funct3[2:1] != 2'b01);
         end
         OpJalr: begin
            dec.jump        = Jalr;
            dec.reg_wb      = 1'b1;
            dec.alu_use_imm = 1'b1;
            dec.imm         = imm_i;
            legal           = (funct3 == 3'b000);
         end
         OpJal: begin
            dec.jump   = Jal;
            dec.reg_wb = 1'b1;
            dec.imm    = imm_j;
         end
         OpImm: begin
            dec.aluop       = Funct;
            dec.alu_use_imm = 1'b1;
            dec.reg_wb      = 1'b1;
            dec.imm         = imm_i;
            legal = !(Rv32 && funct3[1:0] == 2'b01 && instr_i[25]);
         end
         OpReg: begin
            dec.aluop  = Funct;
            dec.reg_wb = 1'b1;
         end
         OpImm32: begin
            dec.aluop       = Op32;
            dec.alu_use_imm = 1'b1;
            dec.reg_wb      = 1'b1;
            dec.imm         = imm_i;
            legal           = !Rv32;
         end
         OpReg32: begin
            dec.aluop  = Op32;
            dec.reg_wb = 1'b1;
            legal      = !Rv32;
         end
         OpLui: begin
            dec.reg_wb      = 1'b1;
            dec.reg_lui     = 1'b1;
            dec.alu_use_imm = 1'b1;
            dec.imm         = imm_u;
         end
         OpAuipc: begin
            dec.reg_wb      = 1'b1;
            dec.is_auipc    = 1'b1;
            dec.alu_use_imm = 1'b1;
            dec.imm         = imm_u;
         end
         OpFence: dec.fence = 1'b1;
         OpSystem: begin
            if (instr_i == EcallEnc)       dec.ecall  = 1'b1;
            else if (instr_i == EbreakEnc) dec.ebreak = 1'b1;
            else                           legal      = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
      dec.pc     = pc_i;
      dec.rd     = instr_i[11:7];
      dec.rs1    = instr_i[19:15];
      dec.rs2    = instr_i[24:20];
      dec.funct3 = funct3;
      dec.funct7 = instr_i[31:25];
   end

   state_e  state_q, state_d;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    ready_q, ready_d;
   logic    accept, consume;

   assign valid_o = (state_q != StEmpty);
   assign ready_o = ready_q;
   assign accept  = valid_i && ready_q;
   assign consume = valid_o && ready_i;
   assign ready_d = (state_d != StFull);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  out_d   = dec;
               end
            end
            StOne: begin
               if (accept && consume) begin
                  out_d = dec;
               end else if (accept) begin
                  state_d = StFull;
                  skid_d  = dec;
               end else if (consume) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (consume) begin
                  state_d = StOne;
                  out_d   = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StEmpty;
         ready_q <= 1'b1;
         // NOTE: payload registers are reset too, so outputs read as a clean NOP bundle after reset.
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign pc_o          = out_q.pc;
   assign rd_o          = out_q.rd;
   assign rs1_o         = out_q.rs1;
   assign rs2_o         = out_q.rs2;
   assign funct3_o      = out_q.funct3;
   assign funct7_o      = out_q.funct7;
   assign imm_o         = out_q.imm;
   assign aluop_o       = out_q.aluop;
   assign alu_use_imm_o = out_q.alu_use_imm;
   assign reg_wb_o      = out_q.reg_wb;
   assign reg_lui_o     = out_q.reg_lui;
   assign is_auipc_o    = out_q.is_auipc;
   assign branch_o      = out_q.branch;
   assign mem_to_reg_o  = out_q.mem_to_reg;
   assign jump_o        = out_q.jump;
   assign mem_type_o    = out_q.mem_type;
   assign ecall_o       = out_q.ecall;
   assign ebreak_o      = out_q.ebreak;
   assign fence_o       = out_q.fence;
   assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: drives Xlen=64 and Xlen=32 instances with the same
// stream and checks both against an opcode-table reference decoder and an occupancy model.

module tb_decode_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [63:0] imm;
      logic [1:0]  aluop;
      logic        alu_use_imm;
      logic        reg_wb;
      logic        reg_lui;
      logic        is_auipc;
      logic        branch;
      logic        mem_to_reg;
      logic [1:0]  jump;
      logic [1:0]  mem_type;
      logic        ecall;
      logic        ebreak;
      logic        fence;
      logic        illegal;
   } exp_t;

   logic        clk;
   logic        rst_i, flush_i, valid_i, ready_i;
   logic [31:0] instr_i;
   logic [63:0] pc_i;

   logic        d64_ready, d64_valid, d32_ready, d32_valid;
   logic [63:0] d64_pc, d64_imm;
   logic [31:0] d32_pc, d32_imm;
   logic [4:0]  d64_rd, d64_rs1, d64_rs2, d32_rd, d32_rs1, d32_rs2;
   logic [2:0]  d64_f3, d32_f3;
   logic [6:0]  d64_f7, d32_f7;
   logic [1:0]  d64_aluop, d64_jump, d64_mem, d32_aluop, d32_jump, d32_mem;
   logic        d64_use_imm, d64_wb, d64_lui, d64_auipc, d64_br, d64_m2r;
   logic        d64_ecall, d64_ebreak, d64_fence, d64_ill;
   logic        d32_use_imm, d32_wb, d32_lui, d32_auipc, d32_br, d32_m2r;
   logic        d32_ecall, d32_ebreak, d32_fence, d32_ill;

   decode_stage #(.Xlen(64), .Ilen(32)) dut64 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(d64_ready),
      .instr_i(instr_i), .pc_i(pc_i), .valid_o(d64_valid), .ready_i(ready_i), .pc_o(d64_pc),
      .rd_o(d64_rd), .rs1_o(d64_rs1), .rs2_o(d64_rs2), .funct3_o(d64_f3), .funct7_o(d64_f7),
      .imm_o(d64_imm), .aluop_o(d64_aluop), .alu_use_imm_o(d64_use_imm), .reg_wb_o(d64_wb),
      .reg_lui_o(d64_lui), .is_auipc_o(d64_auipc), .branch_o(d64_br), .mem_to_reg_o(d64_m2r),
      .jump_o(d64_jump), .mem_type_o(d64_mem), .ecall_o(d64_ecall), .ebreak_o(d64_ebreak),
      .fence_o(d64_fence), .illegal_o(d64_ill)
   );

   decode_stage #(.Xlen(32), .Ilen(32)) dut32 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(d32_ready),
      .instr_i(instr_i), .pc_i(pc_i[31:0]), .valid_o(d32_valid), .ready_i(ready_i), .pc_o(d32_pc),
      .rd_o(d32_rd), .rs1_o(d32_rs1), .rs2_o(d32_rs2), .funct3_o(d32_f3), .funct7_o(d32_f7),
      .imm_o(d32_imm), .aluop_o(d32_aluop), .alu_use_imm_o(d32_use_imm), .reg_wb_o(d32_wb),
      .reg_lui_o(d32_lui), .is_auipc_o(d32_auipc), .branch_o(d32_br), .mem_to_reg_o(d32_m2r),
      .jump_o(d32_jump), .mem_type_o(d32_mem), .ecall_o(d32_ecall), .ebreak_o(d32_ebreak),
      .fence_o(d32_fence), .illegal_o(d32_ill)
   );

   exp_t act64, act32;
   assign act64 = {d64_pc, d64_rd, d64_rs1, d64_rs2, d64_f3, d64_f7, d64_imm, d64_aluop,
                   d64_use_imm, d64_wb, d64_lui, d64_auipc, d64_br, d64_m2r, d64_jump, d64_mem,
                   d64_ecall, d64_ebreak, d64_fence, d64_ill};
   assign act32 = {32'b0, d32_pc, d32_rd, d32_rs1, d32_rs2, d32_f3, d32_f7, 32'b0, d32_imm, d32_aluop,
                   d32_use_imm, d32_wb, d32_lui, d32_auipc, d32_br, d32_m2r, d32_jump, d32_mem,
                   d32_ecall, d32_ebreak, d32_fence, d32_ill};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q64[$];
   exp_t q32[$];
   int   held = 0;
   bit   prev_acc = 1'b0, prev_cons = 1'b0, prev_flush = 1'b0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   function automatic bit f3_ok(input logic [7:0] mask, input logic [2:0] f3);
      return mask[f3];
   endfunction

   // Reference decoder: opcode table with per-opcode legal-funct3 masks; immediates by signed arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc, input bit rv32);
      exp_t        e;
      logic [2:0]  f3;
      logic [63:0] ii, is, ib, iu, ij;
      bit          ok;
      e  = '0;
      ok = 1'b1;
      f3 = ins[14:12];
      ii = 64'($signed(ins[31:20]));
      is = 64'($signed({ins[31:25], ins[11:7]}));
      ib = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
      iu = 64'($signed(ins[31:12])) << 12;
      ij = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
      case (ins[6:0])
         7'h03: begin ok = f3_ok(rv32 ? 8'h37 : 8'h7F, f3); e.alu_use_imm = 1; e.reg_wb = 1;
                      e.mem_to_reg = 1; e.mem_type = 2'd1; e.imm = ii; end
         7'h23: begin ok = f3_ok(rv32 ? 8'h07 : 8'h0F, f3); e.alu_use_imm = 1; e.mem_type = 2'd2;
                      e.imm = is; end
         7'h63: begin ok = f3_ok(8'hF3, f3); e.branch = 1; e.imm = ib; end
         7'h67: begin ok = f3_ok(8'h01, f3); e.jump = 2'd2; e.reg_wb = 1; e.alu_use_imm = 1; e.imm = ii; end
         7'h6F: begin e.jump = 2'd1; e.reg_wb = 1; e.imm = ij; end
         7'h13: begin ok = !(rv32 && (f3 == 3'd1 || f3 == 3'd5) && ins[25]); e.aluop = 2'd1;
                      e.alu_use_imm = 1; e.reg_wb = 1; e.imm = ii; end
         7'h33: begin e.aluop = 2'd1; e.reg_wb = 1; end
         7'h1B: begin ok = !rv32; e.aluop = 2'd2; e.alu_use_imm = 1; e.reg_wb = 1; e.imm = ii; end
         7'h3B: begin ok = !rv32; e.aluop = 2'd2; e.reg_wb = 1; end
         7'h37: begin e.reg_wb = 1; e.reg_lui = 1; e.alu_use_imm = 1; e.imm = iu; end
         7'h17: begin e.reg_wb = 1; e.is_auipc = 1; e.alu_use_imm = 1; e.imm = iu; end
         7'h0F: e.fence = 1;
         7'h73: begin
            if (ins == 32'h0000_0073)      e.ecall  = 1;
            else if (ins == 32'h0010_0073) e.ebreak = 1;
            else                           ok       = 1'b0;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e         = '0;
         e.illegal = 1'b1;
      end
      e.pc     = pc;
      e.rd     = ins[11:7];
      e.rs1    = ins[19:15];
      e.rs2    = ins[24:20];
      e.funct3 = f3;
      e.funct7 = ins[31:25];
      if (rv32) begin
         e.pc[63:32]  = '0;
         e.imm[63:32] = '0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 17))
         0:  r[6:0] = 7'h03;
         1:  r[6:0] = 7'h23;
         2:  r[6:0] = 7'h63;
         3:  r[6:0] = 7'h67;
         4:  r[6:0] = 7'h6F;
         5:  r[6:0] = 7'h13;
         6:  r[6:0] = 7'h33;
         7:  r[6:0] = 7'h1B;
         8:  r[6:0] = 7'h3B;
         9:  r[6:0] = 7'h37;
         10: r[6:0] = 7'h17;
         11: r[6:0] = 7'h0F;
         12: r = 32'h0000_0073;
         13: r = 32'h0010_0073;
         14: begin r[6:0] = 7'h67; r[14:12] = 3'b000; end
         15: r[6:0] = 7'h73;
         default: ;
      endcase
      return r;
   endfunction

   // One cycle of stimulus; the occupancy model advances from the previous cycle's handshake.
   task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                       input bit rdy, input bit fl, input bit r);
      @(posedge clk);
      #2;
      if (prev_flush) begin
         held = 0;
         q64.delete();
         q32.delete();
      end else begin
         held = held + int'(prev_acc) - int'(prev_cons);
      end
      rst_i   = r;
      valid_i = v;
      instr_i = ins;
      pc_i    = pc;
      ready_i = rdy;
      flush_i = fl;
      prev_acc   = v && (held < 2);
      prev_cons  = (held > 0) && rdy;
      prev_flush = fl || r;
      if (prev_acc && !prev_flush) begin
         q64.push_back(ref_decode(ins, pc, 1'b0));
         q32.push_back(ref_decode(ins, pc, 1'b1));
      end
   endtask

   task automatic present(input logic [31:0] ins);
      step(1'b1, ins, 64'h8000_0000_0000_1000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
   endtask

   // Monitor: checks handshake against the occupancy model and the presented bundle against the queue front.
   always @(negedge clk) begin
      if (mon_en) begin
         check("valid64", 256'(d64_valid), 256'(held > 0));
         check("ready64", 256'(d64_ready), 256'(held < 2));
         check("valid32", 256'(d32_valid), 256'(held > 0));
         check("ready32", 256'(d32_ready), 256'(held < 2));
         if (held > 0) begin
            if (q64.size() == 0 || q32.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard: got empty queue with %0d held, want entries", held);
            end else begin
               check(ready_i ? "out64" : "hold64", 256'(act64), 256'(q64[0]));
               check(ready_i ? "out32" : "hold32", 256'(act32), 256'(q32[0]));
               if (ready_i) begin
                  void'(q64.pop_front());
                  void'(q32.pop_front());
               end
            end
         end
      end
   end

   initial begin
      rst_i   = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      instr_i = '0;
      pc_i    = '0;

      // Reset state
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("rst_valid64", 256'(d64_valid), 256'(0));
      check("rst_ready64", 256'(d64_ready), 256'(1));
      check("rst_payload64", 256'(act64), 256'(0));
      check("rst_payload32", 256'(act32), 256'(0));
      mon_en = 1'b1;

      // Streaming addi x1,x0,-1
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'hFFF0_0093, 64'h1000 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("addi_valid", 256'(d64_valid), 256'(1));
      check("addi_imm64", 256'(d64_imm), 256'(64'hFFFF_FFFF_FFFF_FFFF));
      check("addi_imm32", 256'(d32_imm), 256'(32'hFFFF_FFFF));
      check("addi_wb", 256'(d64_wb), 256'(1));
      check("addi_use_imm", 256'(d64_use_imm), 256'(1));
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Back-pressure: third offer refused until the stage drains
      step(1'b1, 32'h0011_0113, 64'h2000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0022_0213, 64'h2004, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0033_0313, 64'h2008, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_ready_low", 256'(d64_ready), 256'(0));
      step(1'b1, 32'h0033_0313, 64'h2008, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h0033_0313, 64'h2008, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Flush while full, with a new instruction offered
      step(1'b1, 32'h0044_0413, 64'h3000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0055_0513, 64'h3004, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0066_0613, 64'h3008, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("flush_valid", 256'(d64_valid), 256'(0));
      check("flush_ready", 256'(d64_ready), 256'(1));
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Xlen-dependent and SYSTEM/FENCE encodings
      present(32'h0010_009B);
      check("addiw_ill32", 256'(d32_ill), 256'(1));
      check("addiw_wb32", 256'(d32_wb), 256'(0));
      check("addiw_aluop64", 256'(d64_aluop), 256'(2));
      check("addiw_ill64", 256'(d64_ill), 256'(0));
      present(32'h0000_0073);
      check("ecall", 256'(d64_ecall), 256'(1));
      present(32'h0010_0073);
      check("ebreak", 256'(d64_ebreak), 256'(1));
      present(32'h3020_0073);
      check("mret_ill", 256'(d64_ill), 256'(1));
      present(32'h0000_000F);
      check("fence", 256'(d64_fence), 256'(1));
      check("fence_wb", 256'(d64_wb), 256'(0));

      // Reset while full clears state and payload
      step(1'b1, 32'hFFF0_0093, 64'h4000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_006F, 64'h4004, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("mid_rst_payload64", 256'(act64), 256'(0));
      check("mid_rst_payload32", 256'(act32), 256'(0));

      // Random stream under random handshake and flush
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), {32'($urandom()), 32'($urandom())},
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("drained", 256'(d64_valid), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
